// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg
//   Shared definitions for the boot-time memory loader.
//   - loader_state_e : frame-reception state machine encoding
//   - HEADER_BYTE    : frame start marker
//   - DATA_BYTES     : bytes per memory word (big-endian on the wire)
//   Optional feature macro: LOADER_CHECKSUM_EN (adds the CSUM state).
package mem_loader_pkg;

    localparam logic [7:0] HEADER_BYTE    = 8'hA5;
    localparam int         LDR_DATA_WIDTH = 16;
    localparam int         DATA_BYTES     = LDR_DATA_WIDTH / 8;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_HDR   = 4'd1,
        ST_ADDR  = 4'd2,
        ST_CNT   = 4'd3,
        ST_HI    = 4'd4,
        ST_LO    = 4'd5,
        ST_WRITE = 4'd6,
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM  = 4'd7,
`endif
        ST_DONE  = 4'd8,
        ST_ERR   = 4'd9
    } loader_state_e;

endpackage

// File: rtl/mem_loader.sv
// mem_loader
//   Receives a framed byte stream (A5, start address, count, count x {hi, lo}
//   [, checksum]) and writes the assembled 16-bit words sequentially into a
//   BRAM through its active-low write port. While not loading, the processor
//   memory port passes straight through to the BRAM.
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     defined   : frame ends with an 8-bit sum of all data bytes; mismatch -> ERR
//     undefined : frame ends after the last data byte
//
// Ports
//   clk_i, reset_i                 clock, synchronous active-high reset
//   start_i                        begin frame reception (IDLE or ERR only)
//   byte_i, byte_valid_i           stream byte and its valid
//   byte_ready_o                   loader accepts byte_i this cycle
//   cpu_address_i/data_i/write_en_ni  processor memory port (passthrough)
//   mem_address_o/data_o/write_en_no  to the BRAM
//   busy_o                         loader owns the memory port
//   done_o                         one-cycle pulse on successful frame end
//   error_o                        sticky frame error, cleared by start_i/reset_i
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int WORDS      = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    input  logic [WORDS-1:0]      cpu_address_i,
    input  logic [DATA_WIDTH-1:0] cpu_data_i,
    input  logic                  cpu_write_en_ni,
    output logic [WORDS-1:0]      mem_address_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  mem_write_en_no,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    loader_state_e state_q, state_d;
    logic [WORDS-1:0] addr_q, addr_d;
    // One bit wider than the count byte so that a count of 0 can mean 256.
    logic [8:0]       count_q, count_d;
    logic [7:0]       hi_q, hi_d;
    logic [7:0]       lo_q, lo_d;
    logic             we_n_q, we_n_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       sum_q, sum_d;
`endif

    logic                  byte_fire;
    logic [DATA_WIDTH-1:0] word_w;

    assign byte_fire = byte_valid_i && byte_ready_o;
    assign word_w    = {hi_q, lo_q};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            we_n_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            we_n_q  <= we_n_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        byte_ready_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_HDR;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            ST_HDR: begin
                byte_ready_o = 1'b1;
                if (byte_fire) begin
                    state_d = (byte_i == HEADER_BYTE) ? ST_ADDR : ST_ERR;
                end
            end
            ST_ADDR: begin
                byte_ready_o = 1'b1;
                if (byte_fire) begin
                    addr_d  = byte_i[WORDS-1:0];
                    state_d = ST_CNT;
                end
            end
            ST_CNT: begin
                byte_ready_o = 1'b1;
                if (byte_fire) begin
                    count_d = (byte_i == 8'd0) ? 9'd256 : {1'b0, byte_i};
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                byte_ready_o = 1'b1;
                if (byte_fire) begin
                    hi_d    = byte_i;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = sum_q + byte_i;
`endif
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                byte_ready_o = 1'b1;
                if (byte_fire) begin
                    lo_d    = byte_i;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = sum_q + byte_i;
`endif
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Address wraps naturally at 2^WORDS.
                addr_d  = addr_q + 1'b1;
                count_d = count_q - 9'd1;
                if (count_q != 9'd1) begin
                    state_d = ST_HI;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = ST_CSUM;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                byte_ready_o = 1'b1;
                if (byte_fire) begin
                    state_d = (byte_i == sum_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                if (start_i) begin
                    state_d = ST_HDR;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Write strobe is registered from the next state, so it is low for
        // exactly the WRITE cycle and glitch-free at the BRAM.
        we_n_d = (state_d != ST_WRITE);
    end

    assign busy_o  = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);
    assign done_o  = (state_q == ST_DONE);
    assign error_o = (state_q == ST_ERR);

    // Port mux: the loader's registers own the BRAM while busy; otherwise the
    // processor drives it directly.
    assign mem_address_o   = busy_o ? addr_q : cpu_address_i;
    assign mem_data_o      = busy_o ? word_w : cpu_data_i;
    assign mem_write_en_no = busy_o ? we_n_q : cpu_write_en_ni;

endmodule

// File: tb/tb_mem_loader.sv
module tb_mem_loader;
    import mem_loader_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic [7:0]  cpu_address_i;
    logic [15:0] cpu_data_i;
    logic        cpu_write_en_ni;
    logic [7:0]  mem_address_o;
    logic [15:0] mem_data_o;
    logic        mem_write_en_no;
    logic        busy_o;
    logic        done_o;
    logic        error_o;

    mem_loader #(.WORDS(8), .DATA_WIDTH(16)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .start_i         (start_i),
        .byte_i          (byte_i),
        .byte_valid_i    (byte_valid_i),
        .byte_ready_o    (byte_ready_o),
        .cpu_address_i   (cpu_address_i),
        .cpu_data_i      (cpu_data_i),
        .cpu_write_en_ni (cpu_write_en_ni),
        .mem_address_o   (mem_address_o),
        .mem_data_o      (mem_data_o),
        .mem_write_en_no (mem_write_en_no),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .error_o         (error_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    typedef struct { logic [7:0] addr; logic [15:0] data; } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [7:0]  hdr;
        logic [7:0]  addr;
        int          cnt;
        logic [15:0] w [3];
        bit          bad_csum;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard: every loader write seen at the BRAM must be the next expected one.
    always @(negedge clk_i) begin
        if (done_o) done_cnt++;
        if (busy_o && mem_write_en_no === 1'b0) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write: addr=%0h data=%0h, none expected", mem_address_o, mem_data_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 32'(mem_address_o), 32'(e.addr));
                check("write_data", 32'(mem_data_o), 32'(e.data));
                $display("write addr=%02h data=%04h", mem_address_o, mem_data_o);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk_i);
        start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk_i);
        byte_i = b;
        byte_valid_i = 1'b1;
        while (byte_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL byte_timeout: ready=%b, required 1 within 50 cycles", byte_ready_o);
        end
        @(posedge clk_i);
        #1 byte_valid_i = 1'b0;
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{hdr: 8'hA5, addr: 8'h10, cnt: 2, w: '{16'h1234, 16'hABCD, 16'h0000}, bad_csum: 1'b0};
        vecs[1] = '{hdr: 8'hA5, addr: 8'hFF, cnt: 2, w: '{16'h0102, 16'h0304, 16'h0000}, bad_csum: 1'b0};
        vecs[2] = '{hdr: 8'h5A, addr: 8'h00, cnt: 1, w: '{16'h1111, 16'h0000, 16'h0000}, bad_csum: 1'b0};
        vecs[3] = '{hdr: 8'hA5, addr: 8'h00, cnt: 3, w: '{16'hBEEF, 16'h0000, 16'hFFFF}, bad_csum: 1'b0};
        vecs[4] = '{hdr: 8'hA5, addr: 8'h40, cnt: 1, w: '{16'h8001, 16'h0000, 16'h0000}, bad_csum: 1'b1};

        reset_i = 1'b1; start_i = 1'b0; byte_i = 8'h00; byte_valid_i = 1'b0;
        cpu_address_i = 8'h33; cpu_data_i = 16'h5555; cpu_write_en_ni = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ready", 32'(byte_ready_o), 32'd0);
        check("rst_busy",  32'(busy_o), 32'd0);
        check("rst_done",  32'(done_o), 32'd0);
        check("rst_error", 32'(error_o), 32'd0);
        check("rst_pass_addr", 32'(mem_address_o), 32'h33);
        @(negedge clk_i);
        reset_i = 1'b0;

        // Processor holds a write request throughout the frames; it must never reach memory.
        cpu_address_i = 8'h77; cpu_data_i = 16'hDEAD; cpu_write_en_ni = 1'b0;

        for (int v = 0; v < 5; v++) begin
            int   d0;
            bit   exp_err;
            logic [7:0] sum;
            d0 = done_cnt;
            sum = 8'h00;
            exp_err = (vecs[v].hdr != HEADER_BYTE) || (CSUM_ON && vecs[v].bad_csum);
            pulse_start();
            #1;
            check("start_busy", 32'(busy_o), 32'd1);
            check("busy_cpu_blocked", 32'(mem_write_en_no), 32'd1);
            send_byte(vecs[v].hdr);
            if (vecs[v].hdr == HEADER_BYTE) begin
                send_byte(vecs[v].addr);
                send_byte(8'(vecs[v].cnt));
                for (int k = 0; k < vecs[v].cnt; k++) begin
                    wr_t e;
                    e.addr = vecs[v].addr + 8'(k);
                    e.data = vecs[v].w[k];
                    exp_q.push_back(e);
                    sum = sum + vecs[v].w[k][15:8] + vecs[v].w[k][7:0];
                    send_byte(vecs[v].w[k][15:8]);
                    send_byte(vecs[v].w[k][7:0]);
                end
                if (CSUM_ON) send_byte(vecs[v].bad_csum ? (sum ^ 8'h01) : sum);
            end
            repeat (6) @(negedge clk_i);
            check("frame_done_pulses", 32'(done_cnt - d0), exp_err ? 32'd0 : 32'd1);
            check("frame_error", 32'(error_o), 32'(exp_err));
            check("frame_writes_left", 32'(exp_q.size()), 32'd0);
            check("frame_busy_after", 32'(busy_o), 32'd0);
            $display("frame %0d hdr=%02h addr=%02h cnt=%0d err=%b done=%0d", v,
                     vecs[v].hdr, vecs[v].addr, vecs[v].cnt, error_o, done_cnt - d0);
        end

        // Reset in the middle of a frame, just after the first HI byte.
        cpu_write_en_ni = 1'b1;
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h20);
        send_byte(8'h02);
        send_byte(8'h99);
        @(negedge clk_i);
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_ready", 32'(byte_ready_o), 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        repeat (4) @(negedge clk_i);
        check("midrst_idle_busy", 32'(busy_o), 32'd0);
        $display("midframe reset busy=%b", busy_o);

        // Passthrough while idle.
        cpu_address_i = 8'h05; cpu_data_i = 16'hBEEF; cpu_write_en_ni = 1'b0;
        #1;
        check("pass_addr", 32'(mem_address_o), 32'h05);
        check("pass_data", 32'(mem_data_o), 32'hBEEF);
        check("pass_we", 32'(mem_write_en_no), 32'd0);
        cpu_write_en_ni = 1'b1;
        #1;
        check("pass_we_hi", 32'(mem_write_en_no), 32'd1);
        $display("passthrough addr=%02h data=%04h", mem_address_o, mem_data_o);

        repeat (2) @(negedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded limit");
        $fatal(1, "timeout");
    end

endmodule
